// File: rtl/eth_pkg.sv
// Shared types and constants for the Ethernet transmit buffer.
// Contents:
//   tx_buf_state_t   - per-bank lifecycle (FREE -> READY -> SENDING -> FREE)
//   ETH_TX_MAX_WORDS - largest payload, in 32-bit words, addressable by the 10-bit addr
//   ack_ptr_w()      - ack FIFO pointer width: one wrap bit above the slot index
package eth_pkg;

  typedef enum logic [1:0] {
    FREE,
    READY,
    SENDING
  } tx_buf_state_t;

  localparam int unsigned ETH_TX_MAX_WORDS = 1023;

  function automatic int unsigned ack_ptr_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/eth_tx_buffer_if.sv
// Consumer-facing bundle between eth_tx_buffer and the Ethernet transmit block.
//   send_data_empty/send_data_re/tx_len : packet descriptor handshake
//   addr/din                            : payload word read port (2-cycle latency)
//   ack_empty/ack_data/ack_re           : show-ahead ack/nack queue
// Modports: master = buffer side, slave = transmit block side.
interface eth_tx_buffer_if;
  logic        send_data_empty;
  logic        send_data_re;
  logic [15:0] tx_len;
  logic [9:0]  addr;
  logic [31:0] din;
  logic        ack_empty;
  logic        ack_data;
  logic        ack_re;

  modport master (
    output send_data_empty, tx_len, din, ack_empty, ack_data,
    input  send_data_re, addr, ack_re
  );

  modport slave (
    input  send_data_empty, tx_len, din, ack_empty, ack_data,
    output send_data_re, addr, ack_re
  );
endinterface

// File: rtl/eth_tx_bram.sv
// Simple dual-port payload RAM, 2**AW x 32.
// Ports: clk, reset (async, active-high, clears only the read registers),
//        we/wa/wd write port, ra read address, dout read data.
// The read path has two registers (RAM output register plus a second stage),
// so dout reflects the word addressed two clocks earlier. Contents are not cleared.
module eth_tx_bram #(
  parameter int unsigned AW = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [31:0]   wd,
  input  logic [AW-1:0] ra,
  output logic [31:0]   dout
);

  logic [31:0] mem [2**AW];
  logic [31:0] q1;

  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q1   <= '0;
      dout <= '0;
    end else begin
      q1   <= mem[ra];
      dout <= q1;
    end
  end

endmodule

// File: rtl/eth_tx_buffer.sv
// Upstream feeder for the Ethernet transmit block: buffers payload words,
// presents one packet descriptor at a time and queues ack/nack requests.
// Ports:
//   clk, reset                      - single clock, async active-high reset
//   wr_en, wr_data, commit          - host payload fill and packet close
//   wr_ready, wr_overflow           - fill bank FREE; sticky dropped-write flag
//   ack_push, ack_push_data         - enqueue ack (1) / nack (0)
//   ack_overflow                    - sticky dropped-push flag (reset only)
//   tx (eth_tx_buffer_if.master)    - consumer side descriptor/data/ack port
// Build option: define ETH_TX_BUF_DOUBLE_EN for two ping-pong banks; without it
// a single bank is used and both bank pointers stay at 0.
module eth_tx_buffer
  import eth_pkg::*;
#(
  parameter int unsigned ACK_DEPTH = 8,
  parameter int unsigned MAX_WORDS = ETH_TX_MAX_WORDS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [31:0] wr_data,
  input  logic        commit,
  output logic        wr_ready,
  output logic        wr_overflow,
  input  logic        ack_push,
  input  logic        ack_push_data,
  output logic        ack_overflow,
  eth_tx_buffer_if.master tx
);

`ifdef ETH_TX_BUF_DOUBLE_EN
  localparam logic        DBL    = 1'b1;
  localparam int unsigned RAM_AW = 11;
`else
  localparam logic        DBL    = 1'b0;
  localparam int unsigned RAM_AW = 10;
`endif
  localparam int unsigned PW = ack_ptr_w(ACK_DEPTH);

  // ---------------- bank control ----------------
  tx_buf_state_t     state [2];
  logic [10:0]       len   [2];
  logic [10:0]       count;
  logic              fill_ptr;
  logic              rd_ptr;
  logic              end_seen;
  logic              do_write;
  logic              commit_ok;
  logic              release_bank;
  logic [RAM_AW-1:0] ram_wa;
  logic [RAM_AW-1:0] ram_ra;

  assign wr_ready     = (state[fill_ptr] == FREE);
  assign do_write     = wr_en && wr_ready && (count < 11'(MAX_WORDS));
  assign commit_ok    = commit && wr_ready;
  // Empty packets have no end address to wait for; release right away.
  assign release_bank = (state[rd_ptr] == SENDING) && ((len[rd_ptr] == '0) || end_seen);

  assign tx.send_data_empty = (state[rd_ptr] != READY);
  assign tx.tx_len          = {5'b0, len[rd_ptr]};

`ifdef ETH_TX_BUF_DOUBLE_EN
  assign ram_wa = {fill_ptr, count[9:0]};
  assign ram_ra = {rd_ptr, tx.addr};
`else
  assign ram_wa = count[9:0];
  assign ram_ra = tx.addr;
`endif

  // Commit only acts on a FREE bank while the read side only acts on READY or
  // SENDING banks, so the two state updates below never target the same bank
  // in the same cycle even when fill_ptr == rd_ptr.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state[0]    <= FREE;
      state[1]    <= FREE;
      len[0]      <= '0;
      len[1]      <= '0;
      count       <= '0;
      fill_ptr    <= 1'b0;
      rd_ptr      <= 1'b0;
      end_seen    <= 1'b0;
      wr_overflow <= 1'b0;
    end else begin
      if (commit) wr_overflow <= 1'b0;
      if (wr_en && !do_write) wr_overflow <= 1'b1;

      if (commit_ok) begin
        state[fill_ptr] <= READY;
        len[fill_ptr]   <= count + 11'(do_write);
        count           <= '0;
        fill_ptr        <= fill_ptr ^ DBL;
      end else if (do_write) begin
        count <= count + 11'd1;
      end

      if (state[rd_ptr] == READY && tx.send_data_re) state[rd_ptr] <= SENDING;

      // end_seen delays release by one edge so tx_len is still valid for the
      // consumer's final end-of-packet compare.
      if (release_bank) begin
        state[rd_ptr] <= FREE;
        rd_ptr        <= rd_ptr ^ DBL;
        end_seen      <= 1'b0;
      end else if (state[rd_ptr] == SENDING && tx.addr == len[rd_ptr][9:0]) begin
        end_seen <= 1'b1;
      end
    end
  end

  eth_tx_bram #(.AW(RAM_AW)) u_bram (
    .clk   (clk),
    .reset (reset),
    .we    (do_write),
    .wa    (ram_wa),
    .wd    (wr_data),
    .ra    (ram_ra),
    .dout  (tx.din)
  );

  // ---------------- ack FIFO ----------------
  logic          ack_mem [ACK_DEPTH];
  logic [PW-1:0] ack_wp;
  logic [PW-1:0] ack_rp;
  logic          ack_full;
  logic          ack_pop;
  logic          ack_wr;

  assign tx.ack_empty = (ack_wp == ack_rp);
  assign ack_full     = (ack_wp[PW-1] != ack_rp[PW-1]) && (ack_wp[PW-2:0] == ack_rp[PW-2:0]);
  assign ack_pop      = tx.ack_re && !tx.ack_empty;
  // A pop in the same cycle frees the head slot, so a push on full is kept.
  assign ack_wr       = ack_push && (!ack_full || ack_pop);
  assign tx.ack_data  = !tx.ack_empty && ack_mem[ack_rp[PW-2:0]];

  always_ff @(posedge clk) begin
    if (ack_wr) ack_mem[ack_wp[PW-2:0]] <= ack_push_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ack_wp       <= '0;
      ack_rp       <= '0;
      ack_overflow <= 1'b0;
    end else begin
      if (ack_wr)  ack_wp <= ack_wp + PW'(1);
      if (ack_pop) ack_rp <= ack_rp + PW'(1);
      if (ack_push && !ack_wr) ack_overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_eth_tx_buffer.sv
// Self-checking bench for eth_tx_buffer: a packet/queue-level reference model
// updated on each rising edge, a negedge compare process over all outputs, and
// directed scenarios with hand-computed literal expectations.
module tb_eth_tx_buffer;

`ifdef ETH_TX_BUF_DOUBLE_EN
  localparam bit DBL = 1'b1;
`else
  localparam bit DBL = 1'b0;
`endif
  localparam int unsigned MAXW = 1023;
  localparam int unsigned D    = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en, commit, ack_push, ack_push_data;
  logic [31:0] wr_data;
  logic        wr_ready, wr_overflow, ack_overflow;

  eth_tx_buffer_if bus ();

  eth_tx_buffer #(.ACK_DEPTH(8), .MAX_WORDS(1023)) dut (
    .clk           (clk),
    .reset         (reset),
    .wr_en         (wr_en),
    .wr_data       (wr_data),
    .commit        (commit),
    .wr_ready      (wr_ready),
    .wr_overflow   (wr_overflow),
    .ack_push      (ack_push),
    .ack_push_data (ack_push_data),
    .ack_overflow  (ack_overflow),
    .tx            (bus.master)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // ---------------- reference model ----------------
  // Bank state: 0 = free, 1 = ready, 2 = sending.
  int          st [2] = '{0, 0};
  int unsigned ln [2] = '{0, 0};
  int unsigned cnt = 0;
  int unsigned fp = 0, rp = 0;
  bit          endflag = 0;
  bit [31:0]   mm [2048];
  bit          mv [2048];
  bit [31:0]   p1 = 0, p2 = 0;
  bit          p1v = 1, p2v = 1;
  bit          aq [$];
  bit          m_ackovf = 0, m_wovf = 0;
  int          rd_st;
  bit          dw, cok, rel;
  int unsigned ridx;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      st = '{0, 0}; ln = '{0, 0}; cnt = 0; fp = 0; rp = 0; endflag = 0;
      p1 = 0; p2 = 0; p1v = 1; p2v = 1;
      aq.delete(); m_ackovf = 0; m_wovf = 0;
    end else begin
      ridx = rp * 1024 + int'(bus.addr);
      p2 = p1; p2v = p1v;
      p1 = mm[ridx]; p1v = mv[ridx];
      dw    = wr_en && st[fp] == 0 && cnt < MAXW;
      cok   = commit && st[fp] == 0;
      rd_st = st[rp];
      rel   = rd_st == 2 && (ln[rp] == 0 || endflag);
      if (commit) m_wovf = 0;
      if (wr_en && !dw) m_wovf = 1;
      if (dw) begin
        mm[fp * 1024 + cnt] = wr_data;
        mv[fp * 1024 + cnt] = 1;
      end
      if (cok) begin
        st[fp] = 1; ln[fp] = cnt + dw; cnt = 0;
        if (DBL) fp = 1 - fp;
      end else if (dw) begin
        cnt++;
      end
      if (rel) begin
        st[rp] = 0; endflag = 0;
        if (DBL) rp = 1 - rp;
      end else begin
        if (rd_st == 1 && bus.send_data_re) st[rp] = 2;
        if (rd_st == 2 && bus.addr == ln[rp]) endflag = 1;
      end
      if (bus.ack_re && aq.size() > 0) void'(aq.pop_front());
      if (ack_push) begin
        if (aq.size() < D) aq.push_back(ack_push_data);
        else m_ackovf = 1;
      end
    end
  end

  always @(negedge clk) begin
    chk("wr_ready", wr_ready, st[fp] == 0);
    chk("wr_overflow", wr_overflow, m_wovf);
    chk("send_data_empty", bus.send_data_empty, st[rp] != 1);
    chk("tx_len", bus.tx_len, ln[rp]);
    chk("ack_empty", bus.ack_empty, aq.size() == 0);
    chk("ack_data", bus.ack_data, (aq.size() > 0) ? aq[0] : 1'b0);
    chk("ack_overflow", ack_overflow, m_ackovf);
    if (p2v) chk("din", bus.din, p2);
  end

  // ---------------- stimulus ----------------
  logic [31:0] w3 [3]     = '{32'hA0A1A2A3, 32'hB0B1B2B3, 32'hC0C1C2C3};
  bit          pat [8]    = '{1, 0, 1, 1, 1, 1, 1, 1};
  bit          popexp [8] = '{0, 1, 1, 1, 1, 1, 1, 0};

  task automatic consume(input int n);
    bus.send_data_re = 1; step(); bus.send_data_re = 0;
    for (int k = 0; k < n + 3; k++) begin
      bus.addr = 10'((k < n) ? k : n);
      step();
    end
    bus.addr = 0;
  endtask

  initial begin
    reset = 1; wr_en = 0; wr_data = 0; commit = 0; ack_push = 0; ack_push_data = 0;
    bus.send_data_re = 0; bus.addr = 0; bus.ack_re = 0;
    repeat (3) step();
    chk("rst_wr_ready", wr_ready, 1);
    chk("rst_send_data_empty", bus.send_data_empty, 1);
    chk("rst_ack_empty", bus.ack_empty, 1);
    chk("rst_ack_data", bus.ack_data, 0);
    chk("rst_tx_len", bus.tx_len, 0);
    chk("rst_din", bus.din, 0);
    chk("rst_wr_overflow", wr_overflow, 0);
    chk("rst_ack_overflow", ack_overflow, 0);
    reset = 0;
    step();

    // Three-word packet, consumer walks addr 0..3.
    for (int i = 0; i < 3; i++) begin
      wr_en = 1; wr_data = w3[i]; step();
    end
    wr_en = 0;
    chk("t1_empty_before_commit", bus.send_data_empty, 1);
    commit = 1; step(); commit = 0;
    chk("t1_empty_after_commit", bus.send_data_empty, 0);
    chk("t1_tx_len", bus.tx_len, 3);
    bus.send_data_re = 1; step(); bus.send_data_re = 0;
    for (int k = 0; k < 6; k++) begin
      if (k >= 2 && k < 5) chk("t1_din_word", bus.din, w3[k-2]);
      if (k == 2) chk("t1_first_byte", {24'h0, bus.din[31:24]}, 32'hA0);
      if (k == 3) chk("t1_tx_len_held", bus.tx_len, 3);
`ifndef ETH_TX_BUF_DOUBLE_EN
      if (k == 4) chk("t1_still_sending", wr_ready, 0);
      if (k == 5) chk("t1_released", wr_ready, 1);
`endif
      bus.addr = 10'((k < 3) ? k : 3);
      step();
    end
    bus.addr = 0;

    // Zero-word packet.
    commit = 1; step(); commit = 0;
    chk("t2_empty", bus.send_data_empty, 0);
    chk("t2_tx_len", bus.tx_len, 0);
    bus.send_data_re = 1; step(); bus.send_data_re = 0;
    chk("t2_empty_after_pop", bus.send_data_empty, 1);
`ifndef ETH_TX_BUF_DOUBLE_EN
    chk("t2_sending", wr_ready, 0);
`endif
    step();
`ifndef ETH_TX_BUF_DOUBLE_EN
    chk("t2_free", wr_ready, 1);
`endif

    // 1025 writes: last two dropped, length clamps at 1023.
    for (int i = 0; i < 1025; i++) begin
      wr_en = 1; wr_data = 32'h1000_0000 + i; step();
    end
    wr_en = 0;
    chk("t3_overflow_set", wr_overflow, 1);
    commit = 1; step(); commit = 0;
    chk("t3_overflow_cleared", wr_overflow, 0);
    chk("t3_tx_len", bus.tx_len, 1023);
    consume(1023);

`ifdef ETH_TX_BUF_DOUBLE_EN
    // Fill the second bank while the first is being sent.
    for (int i = 0; i < 2; i++) begin
      wr_en = 1; wr_data = 32'h1111_0000 + i; step();
    end
    wr_en = 0; commit = 1; step(); commit = 0;
    bus.send_data_re = 1; step(); bus.send_data_re = 0;
    for (int i = 0; i < 2; i++) begin
      chk("t4_wr_ready_fill", wr_ready, 1);
      wr_en = 1; wr_data = 32'h2222_0000 + i; step();
    end
    wr_en = 0; commit = 1; step(); commit = 0;
    chk("t4_wr_ready_blocked", wr_ready, 0);
    for (int k = 0; k < 5; k++) begin
      bus.addr = 10'((k < 2) ? k : 2);
      step();
    end
    bus.addr = 0;
    chk("t4_second_ready", bus.send_data_empty, 0);
    chk("t4_second_len", bus.tx_len, 2);
    consume(2);
`endif

    // Ack FIFO: fill, overflow, pop+push on full, drain.
    for (int i = 0; i < 8; i++) begin
      ack_push = 1; ack_push_data = pat[i]; step();
    end
    ack_push_data = 0; step();
    ack_push = 0;
    chk("t5_ack_overflow", ack_overflow, 1);
    chk("t5_head_kept", bus.ack_data, 1);
    ack_push = 1; ack_push_data = 0; bus.ack_re = 1; step();
    ack_push = 0; bus.ack_re = 0;
    chk("t5_head_after_poppush", bus.ack_data, 0);
    for (int i = 0; i < 8; i++) begin
      chk("t5_not_empty", bus.ack_empty, 0);
      chk("t5_pop_data", bus.ack_data, popexp[i]);
      bus.ack_re = 1; step();
    end
    bus.ack_re = 0;
    chk("t5_drained", bus.ack_empty, 1);
    bus.ack_re = 1; step(); bus.ack_re = 0;
    chk("t5_pop_empty_ignored", bus.ack_empty, 1);
    ack_push = 1; ack_push_data = 1; step(); ack_push = 0;
    chk("t5_push_visible", bus.ack_empty, 0);
    chk("t5_push_data", bus.ack_data, 1);

    // Asynchronous reset while a packet is being sent.
    wr_en = 1; wr_data = 32'hDEADBEEF; step(); wr_en = 0;
    commit = 1; step(); commit = 0;
    bus.send_data_re = 1; step(); bus.send_data_re = 0;
    step();
    chk("t6_din_before_reset", bus.din, 32'hDEADBEEF);
    chk("t6_tx_len_before_reset", bus.tx_len, 1);
    #2 reset = 1;
    #1;
    chk("t6_wr_ready", wr_ready, 1);
    chk("t6_send_data_empty", bus.send_data_empty, 1);
    chk("t6_tx_len", bus.tx_len, 0);
    chk("t6_din", bus.din, 0);
    chk("t6_ack_empty", bus.ack_empty, 1);
    chk("t6_ack_data", bus.ack_data, 0);
    chk("t6_ack_overflow", ack_overflow, 0);
    chk("t6_wr_overflow", wr_overflow, 0);
    step(); step();
    reset = 0;
    step(); step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
